// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage registers.
// ex_mem_ctrl_t : 9-bit control bundle carried next to each payload.
// ex_mem_data_t : 5 x 32-bit datapath bundle (PC, ALU result, operands, instruction).
// Width localparams give the stage register its default bus sizes.
// CTRL_NOP is the control word of a bubble.
// slot_count() turns the two slot valid bits into an occupancy count.
package pipe_pkg;

  typedef struct packed {
    logic       reg_wr_en;
    logic       DMemWR;
    logic [1:0] WB_Sel;
    logic [1:0] store_size;
    logic [2:0] load_size;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [31:0] PC;
    logic [31:0] ALU_out;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] instruction;
  } ex_mem_data_t;

  localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
  localparam int EX_MEM_DATA_W = $bits(ex_mem_data_t);

  localparam ex_mem_ctrl_t CTRL_NOP = '0;

  // Number of valid slots, 0..2.
  function automatic logic [1:0] slot_count(input logic a_valid, input logic b_valid);
    return {1'b0, a_valid} + {1'b0, b_valid};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline storage slot: a valid bit plus data and control registers.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (clears everything)
//   clear             : kill the entry; valid and ctrl go to 0, data keeps its value
//   load              : capture load_data/load_ctrl and mark valid
//   drop              : mark invalid without touching data/ctrl
//   load_data/ctrl    : value captured on load
//   valid, data, ctrl : slot contents
// Priority is reset > clear > load > drop.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = EX_MEM_DATA_W,
  parameter int CTRL_W = EX_MEM_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_r;
  logic [DATA_W-1:0] data_r;
  logic [CTRL_W-1:0] ctrl_r;

  // Slot state update; data is left stale on clear since only valid/ctrl matter for a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      ctrl_r  <= '0;
    end else if (clear) begin
      valid_r <= 1'b0;
      ctrl_r  <= '0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
      ctrl_r  <= load_ctrl;
    end else if (drop) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;
  assign ctrl  = ctrl_r;

endmodule

// File: rtl/pipe_stage_reg_hs.sv
// Generic valid/ready pipeline stage register with optional skid slot.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   flush                : drop every held entry and any entry offered this cycle
//   in_valid/in_ready    : upstream handshake
//   in_data/in_ctrl      : payload and control of the offered entry
//   out_valid/out_ready  : downstream handshake (out_ready low = stall)
//   out_data/out_ctrl    : head entry; out_ctrl reads 0 on bubbles when ZERO_CTRL_ON_BUBBLE
//   occupancy            : number of held entries
// SKID = 1: main (head) slot plus skid slot, in_ready is a register.
// SKID = 0: main slot only, in_ready = !out_valid | out_ready.
module pipe_stage_reg_hs
  import pipe_pkg::*;
#(
  parameter int DATA_W              = EX_MEM_DATA_W,
  parameter int CTRL_W              = EX_MEM_CTRL_W,
  parameter int SKID                = 1,
  parameter int ZERO_CTRL_ON_BUBBLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              accept_s;
  logic              pop_s;
  logic              in_ready_s;
  logic [1:0]        occupancy_s;
  logic              main_valid_s;
  logic [DATA_W-1:0] main_data_s;
  logic [CTRL_W-1:0] main_ctrl_s;
  logic              main_load_s;
  logic              main_drop_s;
  logic [DATA_W-1:0] main_src_data_s;
  logic [CTRL_W-1:0] main_src_ctrl_s;

  assign accept_s = in_valid & in_ready_s;
  assign pop_s    = main_valid_s & out_ready;

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .load      (main_load_s),
    .drop      (main_drop_s),
    .load_data (main_src_data_s),
    .load_ctrl (main_src_ctrl_s),
    .valid     (main_valid_s),
    .data      (main_data_s),
    .ctrl      (main_ctrl_s)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic              skid_valid_s;
      logic [DATA_W-1:0] skid_data_s;
      logic [CTRL_W-1:0] skid_ctrl_s;
      logic              skid_load_s;
      logic              skid_drop_s;
      logic              in_ready_r;

      // Slot steering. The skid only ever holds an entry older than anything upstream,
      // so when it is valid it is the sole source for refilling the head.
      always_comb begin
        main_load_s     = 1'b0;
        main_drop_s     = 1'b0;
        skid_load_s     = 1'b0;
        skid_drop_s     = 1'b0;
        main_src_data_s = in_data;
        main_src_ctrl_s = in_ctrl;
        if (skid_valid_s) begin
          // Both slots full: upstream is blocked, a pop shifts skid into head.
          main_src_data_s = skid_data_s;
          main_src_ctrl_s = skid_ctrl_s;
          main_load_s     = pop_s;
          skid_drop_s     = pop_s;
        end else if (main_valid_s) begin
          main_load_s = accept_s & pop_s;
          main_drop_s = pop_s & ~accept_s;
          skid_load_s = accept_s & ~pop_s;
        end else begin
          main_load_s = accept_s;
        end
      end

      pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .load      (skid_load_s),
        .drop      (skid_drop_s),
        .load_data (in_data),
        .load_ctrl (in_ctrl),
        .valid     (skid_valid_s),
        .data      (skid_data_s),
        .ctrl      (skid_ctrl_s)
      );

      // in_ready is the registered "skid will be empty next cycle", so it never sees out_ready.
      always_ff @(posedge clk) begin
        if (reset) begin
          in_ready_r <= 1'b1;
        end else if (flush) begin
          in_ready_r <= 1'b1;
        end else begin
          in_ready_r <= ~(skid_load_s | (skid_valid_s & ~skid_drop_s));
        end
      end

      assign in_ready_s  = in_ready_r;
      assign occupancy_s = slot_count(main_valid_s, skid_valid_s);
    end else begin : g_single
      // Single slot: load on every accept, empty out on a pop with nothing behind it.
      always_comb begin
        main_src_data_s = in_data;
        main_src_ctrl_s = in_ctrl;
        main_load_s     = accept_s;
        main_drop_s     = pop_s & ~accept_s;
      end

      assign in_ready_s  = ~main_valid_s | out_ready;
      assign occupancy_s = slot_count(main_valid_s, 1'b0);
    end
  endgenerate

  generate
    if (ZERO_CTRL_ON_BUBBLE != 0) begin : g_ctrl_gate
      // A bubble must never present write enables downstream.
      assign out_ctrl = main_valid_s ? main_ctrl_s : {CTRL_W{1'b0}};
    end else begin : g_ctrl_raw
      assign out_ctrl = main_ctrl_s;
    end
  endgenerate

  assign in_ready  = in_ready_s;
  assign out_valid = main_valid_s;
  assign out_data  = main_data_s;
  assign occupancy = occupancy_s;

endmodule

// File: tb/tb_pipe_stage_reg_hs.sv
// Bench for pipe_stage_reg_hs: one SKID=1 and one SKID=0 instance driven from shared
// inputs (in_valid steered by sel), each checked every cycle against a FIFO model,
// plus directed hand-computed checks.
module tb_pipe_stage_reg_hs;

  localparam int DW = 160;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [1:0]    sel;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          v1, v0;

  logic          rdy1, ov1, rdy0, ov0;
  logic [DW-1:0] od1, od0;
  logic [CW-1:0] oc1, oc0;
  logic [1:0]    occ1, occ0;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic chk_en   = 1'b0;
  int   max_occ1 = 0;
  int   max_occ0 = 0;
  int   c0;

  logic [CW+DW-1:0] q1[$];
  logic [CW+DW-1:0] q0[$];
  logic [31:0]      log1[$];
  logic [31:0]      log0[$];
  int               stamp1[$];

  always #5 clk = ~clk;

  // sel: 0 = skid instance only, 1 = single-slot instance only, 2 = both
  assign v1 = in_valid & (sel != 2'd1);
  assign v0 = in_valid & (sel != 2'd0);

  pipe_stage_reg_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .ZERO_CTRL_ON_BUBBLE(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(v1), .in_ready(rdy1),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_ctrl(oc1), .occupancy(occ1)
  );

  pipe_stage_reg_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .ZERO_CTRL_ON_BUBBLE(1)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(v0), .in_ready(rdy0),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_ctrl(oc0), .occupancy(occ0)
  );

  task automatic chkw(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: each instance is a FIFO of depth 2 (skid) or 1 (single, with pop-through).
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    chk_en <= 1'b1;
    if (reset || flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (v1 && q1.size() < 2) begin
        if (q1.size() > 0 && out_ready) void'(q1.pop_front());
        q1.push_back({in_ctrl, in_data});
      end else if (q1.size() > 0 && out_ready) begin
        void'(q1.pop_front());
      end
      if (v0 && (q0.size() == 0 || out_ready)) begin
        if (q0.size() > 0 && out_ready) void'(q0.pop_front());
        q0.push_back({in_ctrl, in_data});
      end else if (q0.size() > 0 && out_ready) begin
        void'(q0.pop_front());
      end
    end
  end

  // Per-cycle comparison against the model, plus logging of popped entries.
  always @(negedge clk) begin
    if (chk_en) begin
      chkw("out_valid1", 192'(ov1), 192'(q1.size() > 0));
      chkw("in_ready1", 192'(rdy1), 192'(q1.size() < 2));
      chkw("occupancy1", 192'(occ1), 192'(q1.size()));
      if (q1.size() > 0) begin
        chkw("out_data1", 192'(od1), 192'(q1[0][DW-1:0]));
        chkw("out_ctrl1", 192'(oc1), 192'(q1[0][CW+DW-1:DW]));
      end else begin
        chkw("bubble_ctrl1", 192'(oc1), 192'(0));
      end
      chkw("out_valid0", 192'(ov0), 192'(q0.size() > 0));
      chkw("in_ready0", 192'(rdy0), 192'(q0.size() == 0 || out_ready));
      chkw("occupancy0", 192'(occ0), 192'(q0.size()));
      if (q0.size() > 0) begin
        chkw("out_data0", 192'(od0), 192'(q0[0][DW-1:0]));
        chkw("out_ctrl0", 192'(oc0), 192'(q0[0][CW+DW-1:DW]));
      end else begin
        chkw("bubble_ctrl0", 192'(oc0), 192'(0));
      end
      if (int'(occ1) > max_occ1) max_occ1 = int'(occ1);
      if (int'(occ0) > max_occ0) max_occ0 = int'(occ0);
      if (ov1 && out_ready) begin
        log1.push_back(od1[31:0]);
        stamp1.push_back(cyc);
      end
      if (ov0 && out_ready) log0.push_back(od0[31:0]);
    end
  end

  task automatic step(input logic v, input logic [31:0] d, input logic [CW-1:0] c,
                      input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = {128'd0, d};
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = {20{8'hA5}};
    in_ctrl   = 9'h1FF;
    out_ready = 1'b0;
    sel       = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    // Reset held with an entry offered: nothing captured
    chkw("rst_out_valid1", 192'(ov1), 192'(0));
    chkw("rst_out_ctrl1", 192'(oc1), 192'(0));
    chkw("rst_occ1", 192'(occ1), 192'(0));
    chkw("rst_out_data1", 192'(od1), 192'(0));
    chkw("rst_out_valid0", 192'(ov0), 192'(0));
    chkw("rst_occ0", 192'(occ0), 192'(0));
    reset    = 1'b0;
    in_valid = 1'b0;
    step(1'b0, 32'd0, 9'h000, 1'b0, 1'b0);
    chkw("post_rst_ready1", 192'(rdy1), 192'(1));
    chkw("post_rst_ready0", 192'(rdy0), 192'(1));

    // Stream of 8 on the skid instance
    sel      = 2'd0;
    max_occ1 = 0;
    log1.delete();
    stamp1.delete();
    c0 = cyc;
    for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 9'h1FF, 1'b1, 1'b0);
    step(1'b0, 32'd0, 9'h000, 1'b1, 1'b0);
    step(1'b0, 32'd0, 9'h000, 1'b1, 1'b0);
    chkw("stream_len", 192'(log1.size()), 192'(8));
    for (int i = 0; i < 8; i++) begin
      if (i < log1.size()) begin
        chkw("stream_data", 192'(log1[i]), 192'(i + 1));
        chkw("stream_cycle", 192'(stamp1[i]), 192'(c0 + i + 1));
      end
    end
    chkw("stream_max_occ", 192'(max_occ1), 192'(1));

    // Stall on the skid instance
    log1.delete();
    step(1'b1, 32'd1, 9'h003, 1'b0, 1'b0);
    chkw("stall_occ_a", 192'(occ1), 192'(1));
    chkw("stall_rdy_a", 192'(rdy1), 192'(1));
    step(1'b1, 32'd2, 9'h005, 1'b0, 1'b0);
    chkw("stall_occ_b", 192'(occ1), 192'(2));
    chkw("stall_rdy_b", 192'(rdy1), 192'(0));
    step(1'b1, 32'd3, 9'h007, 1'b0, 1'b0);
    chkw("stall_occ_c", 192'(occ1), 192'(2));
    chkw("stall_head_c", 192'(od1[31:0]), 192'(1));
    step(1'b1, 32'd3, 9'h007, 1'b1, 1'b0);
    chkw("stall_occ_d", 192'(occ1), 192'(1));
    chkw("stall_head_d", 192'(od1[31:0]), 192'(2));
    step(1'b1, 32'd3, 9'h007, 1'b1, 1'b0);
    chkw("stall_head_e", 192'(od1[31:0]), 192'(3));
    step(1'b0, 32'd0, 9'h000, 1'b1, 1'b0);
    chkw("stall_occ_f", 192'(occ1), 192'(0));
    chkw("stall_len", 192'(log1.size()), 192'(3));
    for (int i = 0; i < 3; i++)
      if (i < log1.size()) chkw("stall_order", 192'(log1[i]), 192'(i + 1));

    // Flush while full, with an entry offered on the flush cycle
    log1.delete();
    step(1'b1, 32'd10, 9'h1FF, 1'b0, 1'b0);
    step(1'b1, 32'd11, 9'h1FF, 1'b0, 1'b0);
    chkw("flush_pre_occ", 192'(occ1), 192'(2));
    step(1'b1, 32'd12, 9'h1FF, 1'b0, 1'b1);
    chkw("flush_valid", 192'(ov1), 192'(0));
    chkw("flush_ctrl", 192'(oc1), 192'(0));
    chkw("flush_occ", 192'(occ1), 192'(0));
    chkw("flush_rdy", 192'(rdy1), 192'(1));
    step(1'b0, 32'd0, 9'h000, 1'b1, 1'b0);
    step(1'b0, 32'd0, 9'h000, 1'b1, 1'b0);
    chkw("flush_nothing_out", 192'(log1.size()), 192'(0));

    // Simultaneous accept and pop with one entry held
    step(1'b1, 32'd20, 9'h0F0, 1'b0, 1'b0);
    chkw("sim_head_a", 192'(od1[31:0]), 192'(20));
    step(1'b1, 32'd21, 9'h00F, 1'b1, 1'b0);
    chkw("sim_head_b", 192'(od1[31:0]), 192'(21));
    chkw("sim_ctrl_b", 192'(oc1), 192'(9'h00F));
    chkw("sim_occ_b", 192'(occ1), 192'(1));
    step(1'b0, 32'd0, 9'h000, 1'b1, 1'b0);

    // Stall on the single-slot instance
    sel = 2'd1;
    log0.delete();
    step(1'b1, 32'd1, 9'h011, 1'b0, 1'b0);
    chkw("s0_occ_a", 192'(occ0), 192'(1));
    chkw("s0_rdy_a", 192'(rdy0), 192'(0));
    step(1'b1, 32'd2, 9'h022, 1'b0, 1'b0);
    chkw("s0_occ_b", 192'(occ0), 192'(1));
    chkw("s0_head_b", 192'(od0[31:0]), 192'(1));
    out_ready = 1'b1;
    #1;
    chkw("s0_rdy_follow_hi", 192'(rdy0), 192'(1));
    out_ready = 1'b0;
    #1;
    chkw("s0_rdy_follow_lo", 192'(rdy0), 192'(0));
    step(1'b1, 32'd2, 9'h022, 1'b1, 1'b0);
    chkw("s0_head_c", 192'(od0[31:0]), 192'(2));
    step(1'b1, 32'd3, 9'h033, 1'b1, 1'b0);
    chkw("s0_head_d", 192'(od0[31:0]), 192'(3));
    step(1'b0, 32'd0, 9'h000, 1'b1, 1'b0);
    chkw("s0_occ_e", 192'(occ0), 192'(0));
    chkw("s0_len", 192'(log0.size()), 192'(3));
    for (int i = 0; i < 3; i++)
      if (i < log0.size()) chkw("s0_order", 192'(log0[i]), 192'(i + 1));
    chkw("s0_max_occ", 192'(max_occ0 <= 1), 192'(1));

    step(1'b0, 32'd0, 9'h000, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
